// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Counts pixel clocks under pix_ce, exports the current coordinate and a pixel
// request to an upstream source with LAT steps of read latency, and delays
// sync/blanking so hs/vs/de line up with the returned colour.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   pix_ce          pixel clock enable; all state advances only when high
//   rgb_in          {r,g,b} from the source, valid LAT steps after its x/y
//   x, y, req       current coordinate and active-area request
//   hs, vs, de      aligned syncs (polarity per HS_POL/VS_POL) and data enable
//   r, g, b         aligned colour, zero outside de
//   line_start      one-clk pulse on horizontal wrap
//   frame_start     one-clk pulse on frame wrap
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CW       = 1,
    parameter int unsigned LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [3*CW-1:0]   rgb_in,
    output logic [11:0]       x,
    output logic [11:0]       y,
    output logic              req,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              line_start,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        HS_ON      = (HS_POL != 0);
    localparam logic        VS_ON      = (VS_POL != 0);

    // Raster counters
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        h_wrap, v_wrap;

    assign h_wrap = (hcnt_q == H_LAST);
    assign v_wrap = (vcnt_q == V_LAST);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_ce) begin
            if (h_wrap) begin
                hcnt_d = '0;
                vcnt_d = v_wrap ? 12'd0 : vcnt_q + 12'd1;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign x   = hcnt_q;
    assign y   = vcnt_q;
    assign req = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

    // Raw sync is "true = in sync"; polarity is applied at the output register
    logic hsync_raw, vsync_raw;
    assign hsync_raw = (hcnt_q >= H_SYNC_BEG) && (hcnt_q <= H_SYNC_END);
    assign vsync_raw = (vcnt_q >= V_SYNC_BEG) && (vcnt_q <= V_SYNC_END);

    // Delay line matching the upstream read latency: {hsync, vsync, req}
    logic [2:0] raw_vec;
    logic [2:0] dly_vec;
    assign raw_vec = {hsync_raw, vsync_raw, req};

    if (LAT == 0) begin : g_no_dly
        assign dly_vec = raw_vec;
    end else begin : g_dly
        logic [2:0] dly_q [LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(LAT); i++) begin
                    dly_q[i] <= '0;
                end
            end else if (pix_ce) begin
                dly_q[0] <= raw_vec;
                for (int i = 1; i < int'(LAT); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign dly_vec = dly_q[LAT-1];
    end

    // Output register, aligned with rgb_in of the same coordinate
    logic              hs_q, vs_q, de_q;
    logic [3*CW-1:0]   rgb_q;
    logic              line_start_q, frame_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else if (pix_ce) begin
            hs_q  <= dly_vec[2] ? HS_ON : ~HS_ON;
            vs_q  <= dly_vec[1] ? VS_ON : ~VS_ON;
            de_q  <= dly_vec[0];
            rgb_q <= dly_vec[0] ? rgb_in : '0;
        end
    end

    // Pulses are re-evaluated every clk so they never stretch across idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pix_ce & h_wrap;
            frame_start_q <= pix_ce & h_wrap & v_wrap;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign r           = rgb_q[3*CW-1:2*CW];
    assign g           = rgb_q[2*CW-1:CW];
    assign b           = rgb_q[CW-1:0];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a small raster with LAT=3 and a tiny raster
// with LAT=0 and active-high syncs, both checked against an arithmetic model
// of step count since reset, plus a hand-derived table for the tiny raster.
module tb_vga_timing_gen;

    // Main instance: H 8/2/3/2 (15), V 4/1/2/1 (8), LAT=3, active-low syncs, CW=2
    localparam int LAT_M = 3;
    // Tiny instance: H 4/1/1/1 (7), V 2/1/1/1 (5), LAT=0, active-high syncs, CW=1
    localparam int LAT_T = 0;

    logic clk = 1'b0;
    logic rst;
    logic pix_ce;
    logic [5:0] rgb_m;
    logic [2:0] rgb_t;

    logic [11:0] x_m, y_m, x_t, y_t;
    logic req_m, hs_m, vs_m, de_m, ls_m, fs_m;
    logic req_t, hs_t, vs_t, de_t, ls_t, fs_t;
    logic [1:0] r_m, g_m, b_m;
    logic r_t, g_t, b_t;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(2), .LAT(LAT_M)
    ) u_main (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .rgb_in(rgb_m),
        .x(x_m), .y(y_m), .req(req_m), .hs(hs_m), .vs(vs_m), .de(de_m),
        .r(r_m), .g(g_m), .b(b_m), .line_start(ls_m), .frame_start(fs_m)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CW(1), .LAT(LAT_T)
    ) u_tiny (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .rgb_in(rgb_t),
        .x(x_t), .y(y_t), .req(req_t), .hs(hs_t), .vs(vs_t), .de(de_t),
        .r(r_t), .g(g_t), .b(b_t), .line_start(ls_t), .frame_start(fs_t)
    );

    int total = 0;
    int bad   = 0;

    // Model state: number of advancing pix_ce edges since reset, and whether
    // the most recent clk edge advanced
    int         k = 0;
    bit         ce_last = 1'b0;
    logic [5:0] colarr [8192];

    typedef struct {
        int k;
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl [11];

    // Expected {x,y,req,hs,vs,de,rgb(6),line_start,frame_start} after k steps
    function automatic logic [35:0] model(input int ha, hfp, hsw, hbp,
                                          input int va, vfp, vsw, vbp, lat,
                                          input bit hpol, vpol,
                                          input logic [5:0] cmask);
        int ht, vt, h, v, j, hd, vd;
        bit hsa, vsa, dd, ls;
        logic [5:0] c;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        h   = k % ht;
        v   = (k / ht) % vt;
        j   = k - 1 - lat;
        hsa = 1'b0;
        vsa = 1'b0;
        dd  = 1'b0;
        c   = '0;
        if (j >= 0) begin
            hd  = j % ht;
            vd  = (j / ht) % vt;
            hsa = (hd >= ha + hfp) && (hd < ha + hfp + hsw);
            vsa = (vd >= va + vfp) && (vd < va + vfp + vsw);
            dd  = (hd < ha) && (vd < va);
            if (dd) c = colarr[j] & cmask;
        end
        ls = ce_last && (h == 0);
        return {12'(h), 12'(v), (h < ha) && (v < va), hpol ? hsa : !hsa,
                vpol ? vsa : !vsa, dd, c, ls, ls && (v == 0)};
    endfunction

    task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
        end
    endtask

    task automatic check_all();
        cmp("main", {x_m, y_m, req_m, hs_m, vs_m, de_m, r_m, g_m, b_m, ls_m, fs_m},
            model(8, 2, 3, 2, 4, 1, 2, 1, LAT_M, 1'b0, 1'b0, 6'h3f));
        cmp("tiny", {x_t, y_t, req_t, hs_t, vs_t, de_t, 3'b000, r_t, g_t, b_t, ls_t, fs_t},
            model(4, 1, 1, 1, 2, 1, 1, 1, LAT_T, 1'b1, 1'b1, 6'h07));
    endtask

    task automatic check_tbl();
        for (int e = 0; e < 11; e++) begin
            if (tbl[e].k == k) begin
                cmp("tiny_tbl", {12'b0, x_t, y_t, hs_t, vs_t, de_t, ls_t, fs_t},
                    {12'b0, 12'(tbl[e].x), 12'(tbl[e].y), tbl[e].hs, tbl[e].vs,
                     tbl[e].de, tbl[e].ls, tbl[e].fs});
            end
        end
    endtask

    // One clk: drive inputs, take the edge, sample 1 time unit later
    task automatic step(input bit ce);
        int idx;
        pix_ce = ce;
        idx = k - LAT_M;
        rgb_m = (ce && !rst && idx >= 0) ? colarr[idx] : 6'($urandom);
        idx = k - LAT_T;
        rgb_t = (ce && !rst && idx >= 0) ? colarr[idx][2:0] : 3'($urandom);
        @(posedge clk);
        #1;
        ce_last = ce && !rst;
        if (ce_last) k++;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) colarr[i] = 6'($urandom);

        //         k   x  y  hs vs de ls fs
        tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  1, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{6,  6, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{7,  0, 1, 0, 0, 0, 1, 0};
        tbl[4]  = '{8,  1, 1, 0, 0, 1, 0, 0};
        tbl[5]  = '{21, 0, 3, 0, 0, 0, 1, 0};
        tbl[6]  = '{22, 1, 3, 0, 1, 0, 0, 0};
        tbl[7]  = '{28, 0, 4, 0, 1, 0, 1, 0};
        tbl[8]  = '{35, 0, 0, 0, 0, 0, 1, 1};
        tbl[9]  = '{36, 1, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{70, 0, 0, 0, 0, 0, 1, 1};

        rst    = 1'b1;
        pix_ce = 1'b0;
        rgb_m  = '0;
        rgb_t  = '0;
        step(1'b1);
        step(1'b1);
        check_tbl();

        // Continuous pix_ce from reset release: hand-derived tiny-raster points
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1);
            check_tbl();
        end

        // Random enable pattern
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0);

        // Enable every other clk
        for (int i = 0; i < 300; i++) step(i[0]);

        // Asynchronous reset mid-line, visible before the next clk edge
        for (int i = 0; i < 7; i++) step(1'b1);
        #2 rst = 1'b1;
        #1;
        k       = 0;
        ce_last = 1'b0;
        check_all();
        for (int i = 0; i < 3; i++) step($urandom_range(0, 1) != 0);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) step($urandom_range(0, 4) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
